// File: rtl/sfm_cast_out_if.sv
// Control type and valid/ready stream interface shared by the FP-to-integer output cast.
// The package rides along here so the interface file is the only dependency of the converter.
package sfm_cast_pkg;
    typedef struct packed {
        logic       enable;
        logic       is_signed;
        logic [5:0] int_bits;
    } cast_ctrl_t;
endpackage

interface sfm_cast_out_if #(
    parameter int unsigned DATA_WIDTH = 96
) ();
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, data, strb, input ready);
    modport slave (input valid, data, strb, output ready);
endinterface

// File: rtl/sfm_cast_out.sv
// Two-stage pipelined FP-to-integer cast: rescale by the fixed-point convention, round to
// nearest-even, saturate to INT_WIDTH and pack into the low bits of the output beat.
module sfm_cast_out
    import sfm_cast_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 96,
    parameter int unsigned EXP_BITS   = 8,
    parameter int unsigned MANT_BITS  = 7,
    parameter int unsigned INT_WIDTH  = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clear_i,
    input  cast_ctrl_t     ctrl_i,
    sfm_cast_out_if.slave  stream_i,
    sfm_cast_out_if.master stream_o
);
    localparam int unsigned ACTUAL_DW = DATA_WIDTH - 32;
    localparam int unsigned FP_WIDTH  = 1 + EXP_BITS + MANT_BITS;
    localparam int unsigned BIAS      = 2 ** (EXP_BITS - 1) - 1;
    localparam int unsigned NUM_ROWS  = (INT_WIDTH <= FP_WIDTH) ? ACTUAL_DW / FP_WIDTH
                                                                : ACTUAL_DW / INT_WIDTH;
    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned FPB       = FP_WIDTH / 8;
    localparam int unsigned IB        = INT_WIDTH / 8;
    localparam int unsigned SW        = MANT_BITS + 1;
    localparam int unsigned KW        = ((EXP_BITS > 7) ? EXP_BITS : 7) + $clog2(MANT_BITS + 2) + 2;
    localparam int unsigned MW        = ((SW > INT_WIDTH + 1) ? SW : INT_WIDTH + 1) + 1;
    localparam int unsigned LW        = SW + INT_WIDTH + 1;
    localparam int unsigned RW        = SW + MANT_BITS + 3;
    localparam logic [MW-1:0] NEG_MAG = MW'(64'd1 << (INT_WIDTH - 1));

    logic s1_ready, s2_ready;
    logic s1_valid_q, s2_valid_q;
    logic s1_enable_q, s1_signed_q;
    logic [DATA_WIDTH-1:0] s1_data_q, s2_data_q, s2_data_d;
    logic [STRB_W-1:0]     s1_strb_q, s2_strb_q, s2_strb_d;

    logic [NUM_ROWS-1:0][SW-1:0] sig_d, sig_q;
    logic [NUM_ROWS-1:0][KW-1:0] k_d, k_q;
    logic [NUM_ROWS-1:0] sgn_d, sgn_q, zero_d, zero_q, inf_d, inf_q, nan_d, nan_q;
    logic [NUM_ROWS-1:0][INT_WIDTH-1:0] res_lane;
    logic [NUM_ROWS-1:0][IB-1:0]        strb_lane;
    logic [INT_WIDTH-1:0] pos_max, neg_lim;

    assign s2_ready       = !s2_valid_q || stream_o.ready;
    assign s1_ready       = !s1_valid_q || s2_ready;
    assign stream_i.ready = s1_ready;
    assign stream_o.valid = s2_valid_q;
    assign stream_o.data  = s2_data_q;
    assign stream_o.strb  = s2_strb_q;

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_s1
        logic [FP_WIDTH-1:0]  lane;
        logic [EXP_BITS-1:0]  exp_f, exp_eff;
        logic [MANT_BITS-1:0] man_f;
        assign lane      = stream_i.data[i*FP_WIDTH +: FP_WIDTH];
        assign exp_f     = lane[FP_WIDTH-2 -: EXP_BITS];
        assign man_f     = lane[MANT_BITS-1:0];
        assign exp_eff   = (exp_f == '0) ? EXP_BITS'(1) : exp_f;
        assign sig_d[i]  = {exp_f != '0, man_f};
        // Modular KW-bit arithmetic; KW leaves headroom so the two's-complement k is exact.
        assign k_d[i]    = KW'(exp_eff) - KW'(BIAS) + KW'(INT_WIDTH) - KW'(ctrl_i.is_signed)
                           - KW'(ctrl_i.int_bits) - KW'(MANT_BITS);
        assign sgn_d[i]  = lane[FP_WIDTH-1];
        assign zero_d[i] = (exp_f == '0) && (man_f == '0);
        assign inf_d[i]  = (&exp_f) && (man_f == '0);
        assign nan_d[i]  = (&exp_f) && (man_f != '0);
    end

    assign pos_max = s1_signed_q ? {1'b0, {(INT_WIDTH-1){1'b1}}} : {INT_WIDTH{1'b1}};
    assign neg_lim = s1_signed_q ? {1'b1, {(INT_WIDTH-1){1'b0}}} : '0;

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_s2
        logic [LW-1:0]        shl;
        logic [RW-1:0]        shr;
        logic [KW-1:0]        nk, rsh;
        logic [SW-1:0]        ip;
        logic                 grd, stk, ovf;
        logic [MW-1:0]        mag;
        logic [INT_WIDTH-1:0] neg, res;

        assign shl = LW'(sig_q[i]) << k_q[i];
        assign nk  = -k_q[i];
        // Beyond MANT+2 every significand bit already lands in the sticky field.
        assign rsh = (nk > KW'(MANT_BITS + 2)) ? KW'(MANT_BITS + 2) : nk;
        assign shr = (RW'(sig_q[i]) << (MANT_BITS + 3)) >> rsh;
        assign ip  = shr[RW-1 -: SW];
        assign grd = shr[MANT_BITS+2];
        assign stk = |shr[MANT_BITS+1:0];
        assign neg = ~mag[INT_WIDTH-1:0] + INT_WIDTH'(1);

        always_comb begin
            ovf = 1'b0;
            mag = '0;
            if (!k_q[i][KW-1]) begin
                if (k_q[i] > KW'(INT_WIDTH)) begin
                    ovf = 1'b1;
                end else begin
                    ovf = |shl[LW-1:INT_WIDTH+1];
                    mag = MW'(shl[INT_WIDTH:0]);
                end
            end else begin
                mag = MW'(ip) + MW'(grd & (stk | ip[0]));
            end
        end

        always_comb begin
            if (nan_q[i]) begin
                res = pos_max;
            end else if (inf_q[i]) begin
                res = sgn_q[i] ? neg_lim : pos_max;
            end else if (zero_q[i]) begin
                res = '0;
            end else if (sgn_q[i]) begin
                if (!s1_signed_q) begin
                    res = '0;
                end else if (ovf || (mag > NEG_MAG)) begin
                    res = neg_lim;
                end else begin
                    res = neg;
                end
            end else if (ovf || (mag > MW'(pos_max))) begin
                res = pos_max;
            end else begin
                res = mag[INT_WIDTH-1:0];
            end
        end

        assign res_lane[i]  = res;
        assign strb_lane[i] = {IB{&s1_strb_q[i*FPB +: FPB]}};
    end

    assign s2_data_d = s1_enable_q ? DATA_WIDTH'(res_lane) : s1_data_q;
    assign s2_strb_d = s1_enable_q ? STRB_W'(strb_lane) : s1_strb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_enable_q <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_data_q   <= '0;
            s1_strb_q   <= '0;
            s2_data_q   <= '0;
            s2_strb_q   <= '0;
            sig_q       <= '0;
            k_q         <= '0;
            sgn_q       <= '0;
            zero_q      <= '0;
            inf_q       <= '0;
            nan_q       <= '0;
        end else begin
            if (clear_i) begin
                s1_valid_q <= 1'b0;
            end else if (s1_ready) begin
                s1_valid_q <= stream_i.valid;
            end
            if (clear_i) begin
                s2_valid_q <= 1'b0;
            end else if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
            end
            if (stream_i.valid && s1_ready) begin
                s1_enable_q <= ctrl_i.enable;
                s1_signed_q <= ctrl_i.is_signed;
                s1_data_q   <= stream_i.data;
                s1_strb_q   <= stream_i.strb;
                sig_q       <= sig_d;
                k_q         <= k_d;
                sgn_q       <= sgn_d;
                zero_q      <= zero_d;
                inf_q       <= inf_d;
                nan_q       <= nan_d;
            end
            if (s1_valid_q && s2_ready) begin
                s2_data_q <= s2_data_d;
                s2_strb_q <= s2_strb_d;
            end
        end
    end
endmodule

// File: tb/tb_sfm_cast_out.sv
// Bench for sfm_cast_out (BF16 lanes, INT8 output): real-valued reference model with a
// scoreboard checked on every output handshake, plus directed beats with literal expectations.
module tb_sfm_cast_out;
    import sfm_cast_pkg::*;

    typedef struct {
        logic [95:0] data;
        logic [11:0] strb;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       clear_i = 1'b0;
    cast_ctrl_t ctrl = '0;
    int         n_pass = 0;
    int         n_total = 0;
    beat_t      sb[$];
    logic       prev_stall = 1'b0;
    logic [95:0] prev_data = '0;
    logic       full_seen = 1'b0;

    sfm_cast_out_if #(.DATA_WIDTH(96)) in_if ();
    sfm_cast_out_if #(.DATA_WIDTH(96)) out_if ();

    sfm_cast_out #(
        .DATA_WIDTH(96),
        .EXP_BITS  (8),
        .MANT_BITS (7),
        .INT_WIDTH (8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .ctrl_i  (ctrl),
        .stream_i(in_if),
        .stream_o(out_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Value of the BF16 lane times 2^(8 - signed - int_bits), rounded half-even and clamped.
    function automatic logic [7:0] model_lane(input logic [15:0] f, input logic sg, input int ib);
        int  e = int'(f[14:7]);
        int  m = int'(f[6:0]);
        real hi = sg ? 127.0 : 255.0;
        real lo = sg ? -128.0 : 0.0;
        real x, fl;
        int  r;
        if (e == 255) begin
            x = (m != 0) ? hi : (f[15] ? lo : hi);
        end else begin
            x = (e == 0) ? real'(m) * pow2(-133) : real'(128 + m) * pow2(e - 134);
            x = x * pow2(8 - int'(sg) - ib);
            if (f[15]) x = -x;
            if (x > 1000.0) x = 1000.0;
            if (x < -1000.0) x = -1000.0;
            fl = $floor(x);
            if ((x - fl > 0.5) || ((x - fl == 0.5) && (($rtoi(fl) % 2) != 0))) fl = fl + 1.0;
            x = fl;
            if (x > hi) x = hi;
            if (x < lo) x = lo;
        end
        r = $rtoi(x);
        return r[7:0];
    endfunction

    function automatic beat_t model_beat(input logic [95:0] d, input logic [11:0] s,
                                         input cast_ctrl_t c);
        beat_t b;
        b.data = '0;
        b.strb = '0;
        if (!c.enable) begin
            b.data = d;
            b.strb = s;
        end else begin
            for (int j = 0; j < 4; j++) begin
                b.data[j*8 +: 8] = model_lane(d[j*16 +: 16], c.is_signed, int'(c.int_bits));
                b.strb[j]        = &s[j*2 +: 2];
            end
        end
        return b;
    endfunction

    function automatic cast_ctrl_t mk_ctrl(input logic en, input logic sg, input int ib);
        cast_ctrl_t c;
        c.enable    = en;
        c.is_signed = sg;
        c.int_bits  = 6'(ib);
        return c;
    endfunction

    // Scoreboard, occupancy-based ready check and stall stability, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_i) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", out_if.valid, 1'b1);
                check("stall_data_held", out_if.data, prev_data);
            end
            check("in_ready", in_if.ready, (sb.size() < 2) || out_if.ready);
            if (sb.size() == 2 && !out_if.ready && !in_if.ready) full_seen = 1'b1;
            if (out_if.valid && out_if.ready) begin
                check("out_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    check("sb_data", out_if.data, e.data);
                    check("sb_strb", out_if.strb, e.strb);
                end
            end
            prev_stall = out_if.valid && !out_if.ready && !clear_i;
            prev_data  = out_if.data;
            if (clear_i) sb.delete();
            else if (in_if.valid && in_if.ready)
                sb.push_back(model_beat(in_if.data, in_if.strb, ctrl));
        end
    end

    task automatic send(input logic [95:0] d, input logic [11:0] s, input cast_ctrl_t c);
        int n = 0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.strb  = s;
        ctrl        = c;
        forever begin
            @(negedge clk);
            if (in_if.ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [95:0] d, input logic [11:0] s);
        int n = 0;
        forever begin
            @(negedge clk);
            if (out_if.valid && out_if.ready) break;
            n++;
            if (n > 50) begin
                check({name, "_timeout"}, 1'b1, 1'b0);
                break;
            end
        end
        check({name, "_data"}, out_if.data, d);
        check({name, "_strb"}, out_if.strb, s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] tbl [8];
        logic [3:0]  pat;
        logic [95:0] d;
        tbl = '{16'h3F80, 16'h3FC0, 16'hBE00, 16'h4100, 16'h3D00, 16'hC0A0, 16'h3E40, 16'h0080};
        pat = 4'b1001;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.strb   = '0;
        out_if.ready = 1'b1;

        check("model_half_even", model_lane(16'h3C00, 1'b1, 1), 8'h00);
        check("model_round_up", model_lane(16'h3CC0, 1'b1, 1), 8'h02);
        check("model_uns_sat", model_lane(16'h3F80, 1'b0, 0), 8'hFF);
        check("model_neg_inf", model_lane(16'hFF80, 1'b1, 1), 8'h80);

        #2;
        check("reset_valid", out_if.valid, 1'b0);
        check("reset_data", out_if.data, 96'h0);
        check("reset_strb", out_if.strb, 12'h0);
        #10 rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Basic conversion and 2-cycle latency.
        send({32'h0, 16'h3C80, 16'hBF80, 16'h3F00, 16'h3F80}, 12'hFFF, mk_ctrl(1, 1, 1));
        @(negedge clk);
        check("lat_cycle1_valid", out_if.valid, 1'b0);
        @(negedge clk);
        check("lat_cycle2_valid", out_if.valid, 1'b1);
        check("t1_data", out_if.data, 96'h01C0_2040);
        check("t1_strb", out_if.strb, 12'h00F);
        @(posedge clk);
        #1;

        // Rounding and saturation.
        send({32'h0, 16'hC000, 16'h4000, 16'h3CC0, 16'h3C00}, 12'hFFF, mk_ctrl(1, 1, 1));
        send({32'h0, 16'h0000, 16'hFF80, 16'h7FC0, 16'hC040}, 12'hFFF, mk_ctrl(1, 1, 1));
        expect_out("t2a", 96'h807F_0200, 12'h00F);
        expect_out("t2b", 96'h0080_7F80, 12'h00F);

        // Unsigned scale and strobe reduction.
        send({32'h0, 16'h3B80, 16'hBF00, 16'h3F80, 16'h3F00}, 12'hFB7, mk_ctrl(1, 0, 0));
        expect_out("t3", 96'h0100_FF80, 12'h005);

        // Back-pressure with ready pattern 1,0,0,1.
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    for (int j = 0; j < 4; j++) d[j*16 +: 16] = tbl[(b + j) % 8];
                    d[95:64] = 32'hA5A5_0000 + 32'(b);
                    send(d, 12'hFFF, mk_ctrl(1, b[0], b % 3));
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_if.ready = pat[c % 4];
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_if.ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", sb.size(), 0);
        check("bp_full_seen", full_seen, 1'b1);

        // Enable switched off on the very next beat.
        send({32'h0, 16'h3C80, 16'hBF80, 16'h3F00, 16'h3F80}, 12'hFFF, mk_ctrl(1, 1, 1));
        send(96'hDEADBEEF_1234_5678_9ABC_DEF0, 12'hA5C, mk_ctrl(0, 1, 1));
        expect_out("t5a", 96'h01C0_2040, 12'h00F);
        expect_out("t5b", 96'hDEADBEEF_1234_5678_9ABC_DEF0, 12'hA5C);

        // Clear with two beats buffered.
        out_if.ready = 1'b0;
        send({32'h0, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 12'hFFF, mk_ctrl(1, 1, 1));
        send({32'h0, 16'h3F00, 16'h3F00, 16'h3F00, 16'h3F00}, 12'hFFF, mk_ctrl(1, 1, 1));
        @(negedge clk);
        check("full_in_ready", in_if.ready, 1'b0);
        check("full_out_valid", out_if.valid, 1'b1);
        @(posedge clk);
        #1 clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
        @(negedge clk);
        check("clear_valid", out_if.valid, 1'b0);
        out_if.ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send({32'h0, 16'h3C80, 16'h3C80, 16'h3C80, 16'h3C80}, 12'hFFF, mk_ctrl(1, 1, 1));
        expect_out("post_clear", 96'h0101_0101, 12'h00F);

        // Asynchronous reset mid-transfer.
        out_if.ready = 1'b0;
        send({32'h0, 16'hBF80, 16'hBF80, 16'hBF80, 16'hBF80}, 12'hFFF, mk_ctrl(1, 1, 1));
        send({32'h0, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 12'hFFF, mk_ctrl(1, 1, 1));
        check("pre_rst_valid", out_if.valid, 1'b1);
        #3 rst_i = 1'b1;
        #1;
        check("rst_valid", out_if.valid, 1'b0);
        check("rst_data", out_if.data, 96'h0);
        check("rst_strb", out_if.strb, 12'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_i = 1'b0;
        out_if.ready = 1'b1;
        @(posedge clk);
        #1;
        send({32'h0, 16'h3F00, 16'hBF80, 16'h3C80, 16'h3F80}, 12'hFFF, mk_ctrl(1, 1, 1));
        expect_out("post_rst", 96'h20C0_0140, 12'h00F);
        repeat (3) @(posedge clk);
        #1;
        check("final_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sfm_cast_out.md
Name: sfm_cast_out

Overview:
Pipelined FP-to-integer converter at the output end of the datapath. It is the inverse of the integer-to-FP input cast.
- Unpacks NUM_ROWS FP lanes from each input beat.
- Rescales each lane by the same fixed-point convention as the input cast, so integer X maps to X*2^(int_bits+is_signed-INT_WIDTH).
- Rounds each lane to nearest-even and saturates it to INT_WIDTH bits.
- Packs the integers into the low bits of the output beat.

Two register stages sit between two hwpe streams, with full throughput and back-pressure support.

Parameters:
DATA_WIDTH, DATA_W, total stream width; top 32 bits are not payload (ACTUAL_DW = DATA_WIDTH-32).
FPFORMAT, FPFORMAT_IN, fpnew format of input lanes (MANT, EXP, BIAS, FP_WIDTH derived via fpnew_pkg).
INT_WIDTH, INT_W, output integer width; multiple of 8, at most 32.
Derived: NUM_ROWS = ACTUAL_DW/FP_WIDTH if INT_WIDTH <= FP_WIDTH, otherwise ACTUAL_DW/INT_WIDTH.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
clear_i  input  1  synchronous flush of pipeline
ctrl_i  input  cast_ctrl_t  enable, is_signed, int_bits
stream_i  sink  DATA_WIDTH  FP lanes, lane i at bits [i*FP_WIDTH +: FP_WIDTH]
stream_o  source  DATA_WIDTH  integer lanes, lane i at bits [i*INT_WIDTH +: INT_WIDTH]

Behaviour:
- Reset (rst_i=1, asynchronous): both stage valids=0 and data/strb regs=0. Therefore stream_o.valid=0, data=0, strb=0.
- clear_i=1 at a clock edge: both valids forced to 0; in-flight beats are dropped. clear_i has priority over acceptance in the same cycle.
- Handshake:
  - s2_ready = !s2_valid | stream_o.ready
  - s1_ready = !s1_valid | s2_ready
  - stream_i.ready = s1_ready
- A beat is accepted when stream_i.valid & stream_i.ready.
- Latency is 2 cycles from acceptance to stream_o.valid. Throughput is 1 beat/cycle.
- stream_o.data and stream_o.strb are held stable while valid & !ready.
- ctrl_i is sampled at acceptance and travels with the beat. A ctrl change affects only later beats.
- Stage 1 (per lane): unpack s, e, m.
  - Significand sig = {e!=0, m}.
  - Effective exponent Eff = max(e,1) - BIAS.
  - Shift k = Eff + INT_WIDTH - is_signed - int_bits - MANT.
  - Register sig, k (signed, wide enough for the full range), s, and class flags (zero, inf, nan).
- Stage 2 (per lane):
  - k >= 0: magnitude = sig<<k; overflow flag if any bit at or above INT_WIDTH+1.
  - k < 0: right shift with guard and sticky bits, then round nearest-even.
  - Saturation limits:
    - signed: positive max 2^(INT_WIDTH-1)-1; negative magnitude max 2^(INT_WIDTH-1), then two's-complement negate.
    - unsigned: max 2^INT_WIDTH-1; any negative input yields 0, including after rounding.
  - ±Inf saturates to the signed limit.
  - NaN yields the positive max.
  - ±0 and underflow yield 0.
- Strobes: int lane strb = AND of the FP lane's FP_WIDTH/8 strobe bits, replicated INT_WIDTH/8 times.
- Output packing: unused upper data/strb bits, including the top 32, are 0.
- enable=0: data and strb pass through unmodified with the same 2-cycle latency and handshake.
- Simultaneous events:
  - accept while s2 drains: both happen and occupancy is unchanged.
  - stream_o.ready low for N cycles: at most 2 beats buffered, after which stream_i.ready=0.

Test Plan:
(Config: BF16, INT_WIDTH=8.)
1. Signed, int_bits=1 (scale 64), enable=1, ready=1. Lanes 0x3F80, 0x3F00, 0xBF80, 0x3C80 -> 0x40, 0x20, 0xC0, 0x01, stream_o.valid exactly 2 cycles after acceptance.
2. Rounding and saturation, signed, int_bits=1. Lanes:
   - 0x3C00 -> 0x00 (0.5 rounds to even)
   - 0x3CC0 -> 0x02
   - 0x4000 -> 0x7F
   - 0xC000 -> 0x80
   - 0xC040 -> 0x80
   - 0x7FC0 -> 0x7F
   - 0xFF80 -> 0x80
   - 0x0000 -> 0x00
3. Unsigned, int_bits=0 (scale 256). Lanes 0x3F00 -> 0x80, 0x3F80 -> 0xFF, 0xBF00 -> 0x00, 0x3B80 -> 0x01 (1/256). Strobes: FP lane strb 2'b11 -> 1, 2'b01 -> 0.
4. Back-pressure: stream 8 beats with stream_o.ready toggling 1,0,0,1.
   - Output order and values match the reference model.
   - stream_i.ready=0 once two beats are buffered.
   - Output data is stable during stall.
5. Mid-stream ctrl/enable: beat A with enable=1, beat B with enable=0 on consecutive cycles -> A converted, B output equals B input bit-exact.
6. clear_i and rst_i:
   - clear_i pulse with 2 beats buffered -> stream_o.valid=0 next cycle and the dropped beats never appear.
   - rst_i asserted asynchronously mid-transfer -> valid, data, strb go to 0 immediately, and the pipeline restarts cleanly after release.
